load_store_unit: RTL and testbench

Parametrised, handshaked load/store unit between the core datapath and data memory. It replaces the combinational load/store size muxing with a registered unit that:
- aligns store data into byte lanes with byte enables;
- sign/zero-extends load data from any lane;
- flags misaligned and illegal-width accesses without touching memory;
- tolerates variable-latency memory acknowledgement, stalling the core through `req_ready`.

---
 rtl/lsu_pkg.sv | 23 ++
 rtl/lsu_align.sv | 77 +++++++
 rtl/load_store_unit.sv | 133 +++++++++++++
 tb/tb_load_store_unit.sv | 239 +++++++++++++++++++++++
 4 files changed

// File: rtl/lsu_pkg.sv
// Shared types, funct3 codes and size decode for the load/store unit.
package lsu_pkg;

  typedef enum logic [1:0] {
    IDLE,
    MEM,
    RESP
  } lsu_state_e;

  localparam logic [2:0] F3_B  = 3'b000;
  localparam logic [2:0] F3_H  = 3'b001;
  localparam logic [2:0] F3_W  = 3'b010;
  localparam logic [2:0] F3_D  = 3'b011;
  localparam logic [2:0] F3_BU = 3'b100;
  localparam logic [2:0] F3_HU = 3'b101;
  localparam logic [2:0] F3_WU = 3'b110;

  // The low two funct3 bits are log2 of the access size in bytes.
  function automatic logic [1:0] size_log2(input logic [2:0] funct3);
    return funct3[1:0];
  endfunction

endpackage

// File: rtl/lsu_align.sv
// Combinational lane alignment: store shift and byte enables, load shift and
// extension, and misaligned/illegal-width detection.
module lsu_align
  import lsu_pkg::*;
#(
  parameter int DATA_W = 32,
  parameter int OFF    = $clog2(DATA_W/8)
) (
  input  logic                we,
  input  logic [2:0]          funct3,
  input  logic [OFF-1:0]      offset,
  input  logic [DATA_W-1:0]   wdata,
  input  logic [DATA_W-1:0]   rdata,
  output logic [DATA_W/8-1:0] be,
  output logic [DATA_W-1:0]   store_data,
  output logic [DATA_W-1:0]   load_data,
  output logic                err
);

  localparam int BE_W = DATA_W/8;

  logic [1:0]        size;
  logic [OFF+2:0]    shamt;
  logic [BE_W-1:0]   size_mask;
  logic [OFF-1:0]    align_mask;
  logic [DATA_W-1:0] shifted;
  logic              illegal;
  logic              misaligned;

  assign size       = size_log2(funct3);
  assign shamt      = {offset, 3'b000};
  assign align_mask = OFF'((4'd1 << size) - 4'd1);

  always_comb begin
    size_mask = '0;
    case (size)
      2'd0: size_mask = BE_W'(8'h01);
      2'd1: size_mask = BE_W'(8'h03);
      2'd2: size_mask = BE_W'(8'h0F);
      2'd3: size_mask = BE_W'(8'hFF);
      default: size_mask = '0;
    endcase
  end

  // Stores only have signed-form codes; WU and D need a 64-bit datapath.
  always_comb begin
    illegal = 1'b0;
    if (we) begin
      illegal = funct3[2] || ((funct3 == F3_D) && (DATA_W != 64));
    end else begin
      illegal = (funct3 == 3'b111) ||
                (((funct3 == F3_D) || (funct3 == F3_WU)) && (DATA_W != 64));
    end
  end

  assign misaligned = |(offset & align_mask);
  assign err        = illegal | misaligned;

  assign be         = size_mask << offset;
  assign store_data = wdata << shamt;
  assign shifted    = rdata >> shamt;

  always_comb begin
    load_data = '0;
    case (funct3)
      F3_B:    load_data = DATA_W'($signed(shifted[7:0]));
      F3_BU:   load_data = DATA_W'(shifted[7:0]);
      F3_H:    load_data = DATA_W'($signed(shifted[15:0]));
      F3_HU:   load_data = DATA_W'(shifted[15:0]);
      F3_W:    load_data = DATA_W'($signed(shifted[31:0]));
      F3_WU:   load_data = DATA_W'(shifted[31:0]);
      F3_D:    load_data = shifted;
      default: load_data = '0;
    endcase
  end

endmodule

// File: rtl/load_store_unit.sv
// Registered, handshaked load/store unit: accepts one op in IDLE, holds the
// memory request until acknowledged, then pulses a one-cycle response.
module load_store_unit
  import lsu_pkg::*;
#(
  parameter int DATA_W     = 32,
  parameter int DM_ADDRESS = 9,
  parameter int OFF        = $clog2(DATA_W/8)
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic                    req_valid,
  output logic                    req_ready,
  input  logic                    req_we,
  input  logic [2:0]              req_funct3,
  input  logic [DATA_W-1:0]       req_addr,
  input  logic [DATA_W-1:0]       req_wdata,
  output logic                    rsp_valid,
  output logic [DATA_W-1:0]       rsp_rdata,
  output logic                    rsp_err,
  output logic                    mem_req,
  output logic                    mem_we,
  output logic [DM_ADDRESS-OFF-1:0] mem_addr,
  output logic [DATA_W/8-1:0]     mem_be,
  output logic [DATA_W-1:0]       mem_wdata,
  input  logic                    mem_ack,
  input  logic [DATA_W-1:0]       mem_rdata
);

  lsu_state_e state, state_next;

  logic                      we_q;
  logic [2:0]                funct3_q;
  logic [OFF-1:0]            offset_q;
  logic                      err_q;
  logic [DM_ADDRESS-OFF-1:0] addr_q;
  logic [DATA_W/8-1:0]       be_q;
  logic [DATA_W-1:0]         wdata_q;
  logic [DATA_W-1:0]         rdata_q;

  logic                      in_idle;
  logic                      sel_we;
  logic [2:0]                sel_funct3;
  logic [OFF-1:0]            sel_offset;
  logic [DATA_W/8-1:0]       al_be;
  logic [DATA_W-1:0]         al_store;
  logic [DATA_W-1:0]         al_load;
  logic                      al_err;
  logic                      unused_addr_bits;

  // The aligner sees the live request while idle and the held op otherwise.
  assign in_idle    = (state == IDLE);
  assign sel_we     = in_idle ? req_we : we_q;
  assign sel_funct3 = in_idle ? req_funct3 : funct3_q;
  assign sel_offset = in_idle ? req_addr[OFF-1:0] : offset_q;

  assign unused_addr_bits = ^req_addr[DATA_W-1:DM_ADDRESS];

  lsu_align #(
    .DATA_W (DATA_W),
    .OFF    (OFF)
  ) u_align (
    .we         (sel_we),
    .funct3     (sel_funct3),
    .offset     (sel_offset),
    .wdata      (req_wdata),
    .rdata      (mem_rdata),
    .be         (al_be),
    .store_data (al_store),
    .load_data  (al_load),
    .err        (al_err)
  );

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) state <= IDLE;
    else        state <= state_next;
  end

  always_comb begin
    state_next = state;
    req_ready  = 1'b0;
    mem_req    = 1'b0;
    rsp_valid  = 1'b0;
    case (state)
      IDLE: begin
        req_ready = 1'b1;
        if (req_valid) state_next = al_err ? RESP : MEM;
      end
      MEM: begin
        mem_req = 1'b1;
        if (mem_ack) state_next = RESP;
      end
      RESP: begin
        rsp_valid  = 1'b1;
        state_next = IDLE;
      end
      default: state_next = IDLE;
    endcase
  end

  // Errors clear the response data at acceptance; stores clear it on ack.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      we_q     <= 1'b0;
      funct3_q <= '0;
      offset_q <= '0;
      err_q    <= 1'b0;
      addr_q   <= '0;
      be_q     <= '0;
      wdata_q  <= '0;
      rdata_q  <= '0;
    end else if (in_idle && req_valid) begin
      we_q     <= req_we;
      funct3_q <= req_funct3;
      offset_q <= req_addr[OFF-1:0];
      err_q    <= al_err;
      addr_q   <= req_addr[DM_ADDRESS-1:OFF];
      be_q     <= al_be;
      wdata_q  <= al_store;
      if (al_err) rdata_q <= '0;
    end else if ((state == MEM) && mem_ack) begin
      rdata_q <= we_q ? '0 : al_load;
    end
  end

  assign mem_we    = mem_req & we_q;
  assign mem_addr  = addr_q;
  assign mem_be    = be_q;
  assign mem_wdata = wdata_q;
  assign rsp_err   = rsp_valid & err_q;
  assign rsp_rdata = rdata_q;

endmodule

// File: tb/tb_load_store_unit.sv
// Directed vector bench driving a 32-bit and a 64-bit load_store_unit.
module tb_load_store_unit;
  import lsu_pkg::*;

  logic        clk = 1'b0;
  logic        reset;
  logic        sel64;
  logic        req_valid;
  logic        req_we;
  logic [2:0]  req_funct3;
  logic [63:0] req_addr;
  logic [63:0] req_wdata;
  logic        mem_ack;
  logic [63:0] mem_rdata;

  logic        a_ready, a_rsp_valid, a_rsp_err, a_mem_req, a_mem_we;
  logic [31:0] a_rdata, a_wdata;
  logic [6:0]  a_mem_addr;
  logic [3:0]  a_be;
  logic        b_ready, b_rsp_valid, b_rsp_err, b_mem_req, b_mem_we;
  logic [63:0] b_rdata, b_wdata;
  logic [5:0]  b_mem_addr;
  logic [7:0]  b_be;

  logic        ready, rsp_valid, rsp_err, mem_req, mem_we;
  logic [63:0] rsp_rdata, mem_addr, mem_be, mem_wdata;

  int checks = 0;
  int failures = 0;

  always #5 clk = ~clk;

  load_store_unit #(.DATA_W(32), .DM_ADDRESS(9)) u_dut32 (
    .clk        (clk),
    .reset      (reset),
    .req_valid  (req_valid & ~sel64),
    .req_ready  (a_ready),
    .req_we     (req_we),
    .req_funct3 (req_funct3),
    .req_addr   (req_addr[31:0]),
    .req_wdata  (req_wdata[31:0]),
    .rsp_valid  (a_rsp_valid),
    .rsp_rdata  (a_rdata),
    .rsp_err    (a_rsp_err),
    .mem_req    (a_mem_req),
    .mem_we     (a_mem_we),
    .mem_addr   (a_mem_addr),
    .mem_be     (a_be),
    .mem_wdata  (a_wdata),
    .mem_ack    (mem_ack & ~sel64),
    .mem_rdata  (mem_rdata[31:0])
  );

  load_store_unit #(.DATA_W(64), .DM_ADDRESS(9)) u_dut64 (
    .clk        (clk),
    .reset      (reset),
    .req_valid  (req_valid & sel64),
    .req_ready  (b_ready),
    .req_we     (req_we),
    .req_funct3 (req_funct3),
    .req_addr   (req_addr),
    .req_wdata  (req_wdata),
    .rsp_valid  (b_rsp_valid),
    .rsp_rdata  (b_rdata),
    .rsp_err    (b_rsp_err),
    .mem_req    (b_mem_req),
    .mem_we     (b_mem_we),
    .mem_addr   (b_mem_addr),
    .mem_be     (b_be),
    .mem_wdata  (b_wdata),
    .mem_ack    (mem_ack & sel64),
    .mem_rdata  (mem_rdata)
  );

  assign ready     = sel64 ? b_ready     : a_ready;
  assign rsp_valid = sel64 ? b_rsp_valid : a_rsp_valid;
  assign rsp_err   = sel64 ? b_rsp_err   : a_rsp_err;
  assign mem_req   = sel64 ? b_mem_req   : a_mem_req;
  assign mem_we    = sel64 ? b_mem_we    : a_mem_we;
  assign rsp_rdata = sel64 ? b_rdata     : 64'(a_rdata);
  assign mem_addr  = sel64 ? 64'(b_mem_addr) : 64'(a_mem_addr);
  assign mem_be    = sel64 ? 64'(b_be)   : 64'(a_be);
  assign mem_wdata = sel64 ? b_wdata     : 64'(a_wdata);

  typedef struct {
    logic        is64;
    logic        we;
    logic [2:0]  funct3;
    logic [63:0] addr;
    logic [63:0] wdata;
    logic [63:0] rdata;
    int          ack_delay;
    logic        err;
    logic [63:0] exp_rdata;
    logic [63:0] exp_addr;
    logic [7:0]  exp_be;
    logic [63:0] exp_wdata;
  } vec_t;

  localparam int NVEC = 23;
  vec_t vecs [NVEC];

  task automatic check_output(input int idx, input string what,
                              input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("[TB] FAIL v%0d %s: got 0x%0h, expected 0x%0h", idx, what, act, exp);
    end
  endtask

  // One full transaction: accept, memory phase (or immediate error), response.
  task automatic apply_stimulus(input int idx, input vec_t v);
    @(negedge clk);
    sel64 = v.is64;
    #1;
    check_output(idx, "req_ready idle", 64'(ready), 64'd1);
    req_valid  = 1'b1;
    req_we     = v.we;
    req_funct3 = v.funct3;
    req_addr   = v.addr;
    req_wdata  = v.wdata;
    @(negedge clk);
    req_we     = 1'($urandom);
    req_funct3 = 3'($urandom);
    req_addr   = {$urandom, $urandom};
    req_wdata  = {$urandom, $urandom};
    if (v.err) begin
      req_valid = 1'b0;
      check_output(idx, "rsp_valid", 64'(rsp_valid), 64'd1);
      check_output(idx, "rsp_err", 64'(rsp_err), 64'd1);
      check_output(idx, "mem_req", 64'(mem_req), 64'd0);
      check_output(idx, "rsp_rdata", rsp_rdata, 64'd0);
    end else begin
      for (int d = 0; d <= v.ack_delay; d++) begin
        check_output(idx, "mem_req", 64'(mem_req), 64'd1);
        check_output(idx, "req_ready busy", 64'(ready), 64'd0);
        check_output(idx, "rsp_valid early", 64'(rsp_valid), 64'd0);
        check_output(idx, "mem_we", 64'(mem_we), 64'(v.we));
        check_output(idx, "mem_addr", mem_addr, v.exp_addr);
        check_output(idx, "mem_be", mem_be, 64'(v.exp_be));
        check_output(idx, "mem_wdata", mem_wdata, v.exp_wdata);
        mem_ack   = (d == v.ack_delay);
        mem_rdata = (d == v.ack_delay) ? v.rdata : {$urandom, $urandom};
        @(negedge clk);
      end
      mem_ack   = 1'b0;
      mem_rdata = {$urandom, $urandom};
      req_valid = 1'b0;
      check_output(idx, "rsp_valid", 64'(rsp_valid), 64'd1);
      check_output(idx, "rsp_err", 64'(rsp_err), 64'd0);
      check_output(idx, "mem_req after ack", 64'(mem_req), 64'd0);
      check_output(idx, "rsp_rdata", rsp_rdata, v.exp_rdata);
    end
    @(negedge clk);
    check_output(idx, "rsp_valid pulse", 64'(rsp_valid), 64'd0);
    check_output(idx, "req_ready back", 64'(ready), 64'd1);
    check_output(idx, "rsp_rdata held", rsp_rdata, v.exp_rdata);
  endtask

  initial begin
    //          is64  we    funct3 addr     wdata                  rdata                  dly err exp_rdata               addr   be     exp_wdata
    vecs[0]  = '{1'b0, 1'b1, F3_B,  64'h013, 64'hA5,                64'h0,                 0, 1'b0, 64'h0,                 64'h4,  8'h08, 64'hA500_0000};
    vecs[1]  = '{1'b0, 1'b0, F3_B,  64'h013, 64'h0,                 64'h8012_3456,         0, 1'b0, 64'hFFFF_FF80,         64'h4,  8'h08, 64'h0};
    vecs[2]  = '{1'b0, 1'b0, F3_BU, 64'h013, 64'h0,                 64'h8012_3456,         1, 1'b0, 64'h0000_0080,         64'h4,  8'h08, 64'h0};
    vecs[3]  = '{1'b0, 1'b0, F3_H,  64'h011, 64'h0,                 64'h0,                 0, 1'b1, 64'h0,                 64'h0,  8'h00, 64'h0};
    vecs[4]  = '{1'b0, 1'b0, F3_W,  64'h008, 64'h0,                 64'hDEAD_BEEF,         3, 1'b0, 64'hDEAD_BEEF,         64'h2,  8'h0F, 64'h0};
    vecs[5]  = '{1'b0, 1'b1, F3_H,  64'h006, 64'hBEEF,              64'h0,                 1, 1'b0, 64'h0,                 64'h1,  8'h0C, 64'hBEEF_0000};
    vecs[6]  = '{1'b0, 1'b0, F3_H,  64'h002, 64'h0,                 64'h9ABC_1234,         0, 1'b0, 64'hFFFF_9ABC,         64'h0,  8'h0C, 64'h0};
    vecs[7]  = '{1'b0, 1'b0, F3_HU, 64'h002, 64'h0,                 64'h9ABC_1234,         2, 1'b0, 64'h0000_9ABC,         64'h0,  8'h0C, 64'h0};
    vecs[8]  = '{1'b0, 1'b1, F3_W,  64'h1FC, 64'h1234_5678,         64'h0,                 0, 1'b0, 64'h0,                 64'h7F, 8'h0F, 64'h1234_5678};
    vecs[9]  = '{1'b0, 1'b0, F3_D,  64'h008, 64'h0,                 64'h0,                 0, 1'b1, 64'h0,                 64'h0,  8'h00, 64'h0};
    vecs[10] = '{1'b0, 1'b1, F3_BU, 64'h004, 64'h11,                64'h0,                 0, 1'b1, 64'h0,                 64'h0,  8'h00, 64'h0};
    vecs[11] = '{1'b0, 1'b0, F3_W,  64'h00A, 64'h0,                 64'h0,                 0, 1'b1, 64'h0,                 64'h0,  8'h00, 64'h0};
    vecs[12] = '{1'b0, 1'b0, F3_BU, 64'h001, 64'h0,                 64'h0000_FF00,         0, 1'b0, 64'h0000_00FF,         64'h0,  8'h02, 64'h0};
    vecs[13] = '{1'b0, 1'b0, F3_WU, 64'h000, 64'h0,                 64'h0,                 0, 1'b1, 64'h0,                 64'h0,  8'h00, 64'h0};
    vecs[14] = '{1'b1, 1'b0, F3_WU, 64'h00C, 64'h0,                 64'h8765_4321_0000_0000, 1, 1'b0, 64'h0000_0000_8765_4321, 64'h1, 8'hF0, 64'h0};
    vecs[15] = '{1'b1, 1'b0, F3_W,  64'h00C, 64'h0,                 64'h8765_4321_0000_0000, 0, 1'b0, 64'hFFFF_FFFF_8765_4321, 64'h1, 8'hF0, 64'h0};
    vecs[16] = '{1'b1, 1'b0, F3_D,  64'h00C, 64'h0,                 64'h0,                 0, 1'b1, 64'h0,                 64'h0,  8'h00, 64'h0};
    vecs[17] = '{1'b1, 1'b1, F3_D,  64'h010, 64'h0123_4567_89AB_CDEF, 64'h0,               2, 1'b0, 64'h0,                 64'h2,  8'hFF, 64'h0123_4567_89AB_CDEF};
    vecs[18] = '{1'b1, 1'b0, F3_D,  64'h018, 64'h0,                 64'hCAFE_BABE_DEAD_BEEF, 0, 1'b0, 64'hCAFE_BABE_DEAD_BEEF, 64'h3, 8'hFF, 64'h0};
    vecs[19] = '{1'b1, 1'b1, F3_B,  64'h00F, 64'h5A,                64'h0,                 0, 1'b0, 64'h0,                 64'h1,  8'h80, 64'h5A00_0000_0000_0000};
    vecs[20] = '{1'b1, 1'b0, F3_H,  64'h006, 64'h0,                 64'h8001_0000_0000_0000, 0, 1'b0, 64'hFFFF_FFFF_FFFF_8001, 64'h0, 8'hC0, 64'h0};
    vecs[21] = '{1'b1, 1'b1, F3_WU, 64'h008, 64'h55,                64'h0,                 0, 1'b1, 64'h0,                 64'h0,  8'h00, 64'h0};
    vecs[22] = '{1'b1, 1'b0, F3_B,  64'h1FF, 64'h0,                 64'h7F00_0000_0000_0000, 0, 1'b0, 64'h0000_0000_0000_007F, 64'h3F, 8'h80, 64'h0};

    reset = 1'b0; sel64 = 1'b0; req_valid = 1'b0; req_we = 1'b0;
    req_funct3 = '0; req_addr = '0; req_wdata = '0; mem_ack = 1'b0; mem_rdata = '0;

    repeat (3) @(negedge clk);
    for (int s = 0; s < 2; s++) begin
      sel64 = (s == 1);
      #1;
      check_output(-1, "reset req_ready", 64'(ready), 64'd1);
      check_output(-1, "reset rsp_valid", 64'(rsp_valid), 64'd0);
      check_output(-1, "reset rsp_err", 64'(rsp_err), 64'd0);
      check_output(-1, "reset mem_req", 64'(mem_req), 64'd0);
      check_output(-1, "reset mem_we", 64'(mem_we), 64'd0);
      check_output(-1, "reset rsp_rdata", rsp_rdata, 64'd0);
      check_output(-1, "reset mem_addr", mem_addr, 64'd0);
      check_output(-1, "reset mem_be", mem_be, 64'd0);
      check_output(-1, "reset mem_wdata", mem_wdata, 64'd0);
    end
    @(negedge clk);
    reset = 1'b1;

    for (int i = 0; i < NVEC; i++) apply_stimulus(i, vecs[i]);

    // Reset in the middle of a memory wait: request drops at once, no response.
    @(negedge clk);
    sel64 = 1'b0;
    req_valid = 1'b1; req_we = 1'b0; req_funct3 = F3_W; req_addr = 64'h20;
    @(negedge clk);
    req_valid = 1'b0;
    check_output(-1, "pre-reset mem_req", 64'(mem_req), 64'd1);
    @(negedge clk);
    #2 reset = 1'b0;
    #1;
    check_output(-1, "async reset mem_req", 64'(mem_req), 64'd0);
    check_output(-1, "async reset rsp_valid", 64'(rsp_valid), 64'd0);
    check_output(-1, "async reset req_ready", 64'(ready), 64'd1);
    @(negedge clk);
    reset = 1'b1;
    mem_ack = 1'b1; mem_rdata = 64'hFFFF_FFFF;
    @(negedge clk);
    mem_ack = 1'b0;
    check_output(-1, "stray ack mem_req", 64'(mem_req), 64'd0);
    check_output(-1, "stray ack rsp_valid", 64'(rsp_valid), 64'd0);
    check_output(-1, "stray ack rsp_rdata", rsp_rdata, 64'd0);
    check_output(-1, "stray ack req_ready", 64'(ready), 64'd1);
    @(negedge clk);
    check_output(-1, "post stray rsp_valid", 64'(rsp_valid), 64'd0);
    check_output(-1, "post stray req_ready", 64'(ready), 64'd1);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
